// File: rtl/spi_bcd_receiver.sv
// SPI mode-0 byte receiver that converts each received byte to two BCD digits
// for a 7-segment decoder; bytes above 99 blank both digits and flag range_err.
module spi_bcd_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       frame_done,
    output logic       range_err
);

    // state | meaning
    // IDLE  | cs_n high, nothing in flight
    // RECV  | cs_n low, shifting bits in
    // CONV  | double-dabble running, one iteration per clk
    // DONE  | single cycle, frame_done high, digits valid
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    logic       sclk_s;
    logic       cs_s;
    logic       mosi_s;
    logic       sclk_prev;
    logic       sclk_rise;

    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       byte_ready;

    logic [7:0]  conv_byte;
    logic [19:0] dd;
    logic [19:0] dd_adj;
    logic [19:0] dd_next;
    logic [2:0]  conv_timer;
    logic        conv_last;

    // cs_n chain resets high so releasing reset never looks like a frame start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;

    // Capture runs whenever cs_n is low, independent of the FSM state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            byte_ready <= 1'b0;
        end else if (cs_s) begin
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            byte_ready <= 1'b0;
        end else begin
            byte_ready <= sclk_rise && (bit_cnt == 3'd7);
            if (sclk_rise) begin
                shift_reg <= {shift_reg[6:0], mosi_s};
                bit_cnt   <= bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!cs_s) state_next = RECV;
            RECV: begin
                if (byte_ready) begin
                    state_next = CONV;
                end else if (cs_s) begin
                    state_next = IDLE;
                end
            end
            CONV: if (conv_last) state_next = DONE;
            DONE: state_next = cs_s ? IDLE : RECV;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        frame_done = (state == DONE);
    end

    // One shift-add-3 step: BCD field in dd[19:8], binary operand in dd[7:0]
    always_comb begin
        dd_adj = dd;
        for (int i = 0; i < 3; i++) begin
            if (dd[8+4*i +: 4] >= 4'd5) begin
                dd_adj[8+4*i +: 4] = dd[8+4*i +: 4] + 4'd3;
            end
        end
        dd_next = {dd_adj[18:0], 1'b0};
    end

    assign conv_last = (state == CONV) && (conv_timer == 3'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conv_byte  <= 8'h00;
            dd         <= 20'h00000;
            conv_timer <= 3'd0;
        end else if (state == RECV && byte_ready) begin
            conv_byte  <= shift_reg;
            dd         <= {12'h000, shift_reg};
            conv_timer <= 3'd7;
        end else if (state == CONV) begin
            dd         <= dd_next;
            conv_timer <= conv_timer - 3'd1;
        end
    end

    // Outputs load on the edge entering DONE so they are valid with frame_done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tens      <= 4'h0;
            ones      <= 4'h0;
            range_err <= 1'b0;
        end else if (conv_last) begin
            if (conv_byte <= 8'd99) begin
                tens      <= dd_next[15:12];
                ones      <= dd_next[11:8];
                range_err <= 1'b0;
            end else begin
                tens      <= 4'hF;
                ones      <= 4'hF;
                range_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_bcd_receiver.sv
// Directed bench for spi_bcd_receiver: SPI bytes at 16 clk per bit, latency,
// range handling, partial frames, reset during conversion, deselected sclk.
module tb_spi_bcd_receiver;

    logic       clk;
    logic       reset_n;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       frame_done;
    logic       range_err;

    int n_cmp;
    int n_bad;
    int fd_count;

    spi_bcd_receiver #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .tens       (tens),
        .ones       (ones),
        .frame_done (frame_done),
        .range_err  (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic spi_bit(input logic b);
        @(negedge clk) mosi = b;
        repeat (8) @(negedge clk);
        sclk = 1'b1;
        repeat (8) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic select_low();
        @(negedge clk) cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic select_high();
        @(negedge clk) cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Sends a byte; k counts negedges after the final sclk rise is driven.
    // lat = first k with frame_done high, -1 if none within 30 cycles.
    task automatic send_observe(input logic [7:0] b, input int cs_rise_k,
                                output int lat, output logic [3:0] t,
                                output logic [3:0] o, output logic re,
                                output logic re_prev);
        for (int i = 7; i >= 1; i--) spi_bit(b[i]);
        @(negedge clk) mosi = b[0];
        repeat (8) @(negedge clk);
        sclk    = 1'b1;
        lat     = -1;
        t       = 4'hx;
        o       = 4'hx;
        re      = 1'bx;
        re_prev = range_err;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 8) sclk = 1'b0;
            if (k == cs_rise_k) cs_n = 1'b1;
            if (frame_done === 1'b1 && lat < 0) begin
                lat = k;
                t   = tens;
                o   = ones;
                re  = range_err;
            end else if (lat < 0) begin
                re_prev = range_err;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (tens !== 4'h0) begin n_bad++; $display("FAIL reset_tens: got %0h want 0", tens); end
        n_cmp++; if (ones !== 4'h0) begin n_bad++; $display("FAIL reset_ones: got %0h want 0", ones); end
        n_cmp++; if (range_err !== 1'b0) begin n_bad++; $display("FAIL reset_range_err: got %b want 0", range_err); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        @(negedge clk) reset_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (fd_count !== 0) begin n_bad++; $display("FAIL reset_release_pulse: got %0d want 0", fd_count); end
    endtask

    // 42 with cs_n raised mid-conversion: DONE must still follow at fixed latency
    task automatic test_basic_latency();
        int lat; logic [3:0] t, o; logic re, rp; int fd0;
        fd0 = fd_count;
        select_low();
        send_observe(8'h2A, 6, lat, t, o, re, rp);
        n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL latency_42: got %0d want 12", lat); end
        n_cmp++; if (t !== 4'd4) begin n_bad++; $display("FAIL tens_42: got %0h want 4", t); end
        n_cmp++; if (o !== 4'd2) begin n_bad++; $display("FAIL ones_42: got %0h want 2", o); end
        n_cmp++; if (re !== 1'b0) begin n_bad++; $display("FAIL range_err_42: got %b want 0", re); end
        n_cmp++; if (fd_count - fd0 !== 1) begin n_bad++; $display("FAIL pulse_width_42: got %0d want 1", fd_count - fd0); end
        select_high();
    endtask

    task automatic test_back_to_back();
        int lat; logic [3:0] t, o; logic re, rp;
        select_low();
        send_observe(8'h63, 0, lat, t, o, re, rp);
        n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL latency_99: got %0d want 12", lat); end
        n_cmp++; if (t !== 4'd9 || o !== 4'd9) begin n_bad++; $display("FAIL digits_99: got %0h%0h want 99", t, o); end
        n_cmp++; if (re !== 1'b0) begin n_bad++; $display("FAIL range_err_99: got %b want 0", re); end
        send_observe(8'h64, 0, lat, t, o, re, rp);
        n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL latency_100: got %0d want 12", lat); end
        n_cmp++; if (t !== 4'hF || o !== 4'hF) begin n_bad++; $display("FAIL digits_100: got %0h%0h want FF", t, o); end
        n_cmp++; if (re !== 1'b1) begin n_bad++; $display("FAIL range_err_100: got %b want 1", re); end
        select_high();
    endtask

    task automatic test_partial_frame();
        int lat; logic [3:0] t, o; logic re, rp; int fd0;
        fd0 = fd_count;
        select_low();
        for (int i = 0; i < 5; i++) spi_bit(1'b1);
        select_high();
        repeat (20) @(negedge clk);
        n_cmp++; if (fd_count !== fd0) begin n_bad++; $display("FAIL partial_pulse: got %0d want %0d", fd_count, fd0); end
        n_cmp++; if (tens !== 4'hF || ones !== 4'hF || range_err !== 1'b1) begin
            n_bad++; $display("FAIL partial_hold: got %0h%0h re=%b want FF re=1", tens, ones, range_err); end
        select_low();
        send_observe(8'h07, 0, lat, t, o, re, rp);
        n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL latency_07: got %0d want 12", lat); end
        n_cmp++; if (t !== 4'd0 || o !== 4'd7) begin n_bad++; $display("FAIL digits_07: got %0h%0h want 07", t, o); end
        n_cmp++; if (re !== 1'b0) begin n_bad++; $display("FAIL range_err_07: got %b want 0", re); end
        n_cmp++; if (fd_count - fd0 !== 1) begin n_bad++; $display("FAIL pulses_07: got %0d want 1", fd_count - fd0); end
        select_high();
    endtask

    task automatic test_reset_during_conv();
        int fd0;
        logic [7:0] b;
        b = 8'h55;
        select_low();
        for (int i = 7; i >= 1; i--) spi_bit(b[i]);
        @(negedge clk) mosi = b[0];
        repeat (8) @(negedge clk);
        sclk = 1'b1;
        repeat (6) @(negedge clk);
        fd0 = fd_count;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (tens !== 4'h0 || ones !== 4'h0) begin n_bad++; $display("FAIL conv_reset_digits: got %0h%0h want 00", tens, ones); end
        n_cmp++; if (range_err !== 1'b0 || frame_done !== 1'b0) begin
            n_bad++; $display("FAIL conv_reset_flags: got re=%b fd=%b want 0 0", range_err, frame_done); end
        repeat (3) @(negedge clk);
        sclk = 1'b0;
        cs_n = 1'b1;
        @(negedge clk) reset_n = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++; if (fd_count !== fd0) begin n_bad++; $display("FAIL conv_reset_pulse: got %0d want %0d", fd_count, fd0); end
        n_cmp++; if (ones !== 4'h0) begin n_bad++; $display("FAIL conv_reset_ones_after: got %0h want 0", ones); end
    endtask

    task automatic test_range_and_deselect();
        int lat; logic [3:0] t, o; logic re, rp; int fd0;
        select_low();
        send_observe(8'hC8, 0, lat, t, o, re, rp);
        n_cmp++; if (t !== 4'hF || o !== 4'hF || re !== 1'b1) begin
            n_bad++; $display("FAIL result_200: got %0h%0h re=%b want FF re=1", t, o, re); end
        select_high();
        fd0 = fd_count;
        for (int i = 0; i < 12; i++) spi_bit(i[0]);
        repeat (10) @(negedge clk);
        n_cmp++; if (fd_count !== fd0) begin n_bad++; $display("FAIL deselect_pulse: got %0d want %0d", fd_count, fd0); end
        n_cmp++; if (tens !== 4'hF || ones !== 4'hF || range_err !== 1'b1) begin
            n_bad++; $display("FAIL deselect_hold: got %0h%0h re=%b want FF re=1", tens, ones, range_err); end
        select_low();
        send_observe(8'h00, 0, lat, t, o, re, rp);
        n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL latency_00: got %0d want 12", lat); end
        n_cmp++; if (rp !== 1'b1) begin n_bad++; $display("FAIL range_err_before_00: got %b want 1", rp); end
        n_cmp++; if (t !== 4'd0 || o !== 4'd0 || re !== 1'b0) begin
            n_bad++; $display("FAIL result_00: got %0h%0h re=%b want 00 re=0", t, o, re); end
        select_high();
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        fd_count = 0;
        reset_n  = 1'b0;
        sclk     = 1'b0;
        cs_n     = 1'b1;
        mosi     = 1'b0;
        test_reset();
        test_basic_latency();
        test_back_to_back();
        test_partial_frame();
        test_reset_during_conv();
        test_range_and_deselect();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_bcd_receiver.md
SPI_BCD_RECEIVER -- requirements
Module: spi_bcd_receiver

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, 2, number of synchronizer flops on each SPI input (min 2).
REQ-002 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: sclk  input  1  SPI serial clock from master, asynchronous to clk, mode 0.
REQ-005 SHALL have port: cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-006 SHALL have port: mosi  input  1  SPI data from master, MSB first.
REQ-007 SHALL have port: tens  output  4  BCD tens digit for downstream 7-segment decoder.
REQ-008 SHALL have port: ones  output  4  BCD ones digit for downstream 7-segment decoder.
REQ-009 SHALL have port: frame_done  output  1  one-cycle pulse when tens/ones update.
REQ-010 SHALL have port: range_err  output  1  high while last converted byte exceeded 99.

Function
REQ-011 SHALL pass sclk, cs_n, mosi each through SYNC_STAGES flops before use; all following references are to synchronized signals.
REQ-012 SHALL detect sclk rising edge as (sync_sclk==1 && previous sync_sclk==0), one clk cycle wide.
REQ-013 While cs_n high: bit counter (3-bit) held at 0, shift register held at 8'h00, no sampling.
REQ-014 While cs_n low, each sclk rising edge SHALL shift mosi into shift register LSB, older bits toward MSB, and increment bit counter modulo 8.
REQ-015 When the 8th bit of a frame is sampled, the complete byte SHALL be copied into a conversion register on the following clk edge and bit counter wraps to 0; further bits while cs_n stays low start a new byte.
REQ-016 cs_n rising before 8 bits: partial byte discarded; tens, ones, range_err, frame_done unaffected.
REQ-017 FSM states: IDLE (cs_n high, no conversion), RECV (cs_n low, shifting), CONV (double-dabble in progress), DONE (one cycle, outputs update).
REQ-018 Transitions: IDLE->RECV on cs_n low; RECV->IDLE on cs_n high; RECV->CONV on byte complete; CONV->DONE after exactly 8 iterations; DONE->RECV if cs_n low else IDLE.
REQ-019 CONV SHALL perform one shift-add-3 double-dabble iteration per clk (add 3 to any BCD nibble >=5 before shift), producing 12-bit hundreds/tens/ones.
REQ-020 Latency: byte-complete sample at cycle N -> frame_done high at cycle N+10 (1 copy + 8 CONV + DONE), fixed.
REQ-021 In DONE, if byte <= 99: tens/ones = BCD digits, range_err = 0; if byte >= 100: tens = ones = 4'hF (blank code for decoder), range_err = 1.
REQ-022 frame_done SHALL be high only during DONE; tens, ones, range_err registered, change only in DONE.
REQ-023 SPI bit capture SHALL continue during CONV/DONE; a byte completing while in CONV/DONE SHALL be dropped with no output effect.
REQ-024 cs_n rising during CONV SHALL NOT abort conversion; DONE still occurs, then IDLE.
REQ-025 Supported sclk: high and low phases each >= SYNC_STAGES+2 clk cycles; behaviour outside this unspecified.

Reset
REQ-026 reset_n low SHALL immediately force: tens=0, ones=0, range_err=0, frame_done=0, FSM=IDLE, bit counter=0, shift and conversion registers=0.
REQ-027 Reset synchronizer values: sclk chain 0, cs_n chain 1, mosi chain 0 (no false edge or frame start on release).
REQ-028 reset_n assertion mid-frame or mid-CONV SHALL discard all partial state; no frame_done after release until a new full byte.

Verification
REQ-029 Send 8'h2A (42) with cs_n low, sclk period 16 clk -> frame_done pulse 1 cycle, tens=4, ones=2, range_err=0, at N+10.
REQ-030 Send 8'h63 (99) then 8'h64 (100) in one cs_n window -> first: tens=9, ones=9, range_err=0; second: tens=4'hF, ones=4'hF, range_err=1.
REQ-031 Send 5 bits then raise cs_n, then full 8'h07 -> no pulse after partial; after full byte tens=0, ones=7.
REQ-032 Assert reset_n low during CONV of 8'h55 -> outputs 0 immediately, no frame_done after release.
REQ-033 Send 8'h00 after prior 8'hC8 (200) -> range_err falls 1->0 in DONE cycle, tens=0, ones=0.
REQ-034 Hold sclk toggling with cs_n high -> no bit capture, no frame_done, outputs unchanged.
